// File: rtl/scratch_read_addr_gen.sv
// Read-address generator for the IF and filter scratchpads.
// Walks every filter window across one IF row, one tap per accepted cycle,
// with a single STRIDE bubble between windows and a DONE pulse at row end.
module scratch_read_addr_gen #(
  parameter int IF_ADDR_LEN   = 4,
  parameter int FILT_ADDR_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reset_all,
  input  logic                     start_rd_gen,
  input  logic [IF_ADDR_LEN-1:0]   if_base,
  input  logic [IF_ADDR_LEN:0]     if_len,
  input  logic [FILT_ADDR_LEN:0]   filt_len,
  input  logic [IF_ADDR_LEN-1:0]   stride,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [IF_ADDR_LEN-1:0]   if_addr,
  output logic [FILT_ADDR_LEN-1:0] filt_addr,
  output logic                     psum_done,
  output logic                     stride_count_flag,
  output logic                     full_done
);

  localparam int WW = IF_ADDR_LEN + 2;    // window-start counter width
  localparam int KW = FILT_ADDR_LEN + 1;  // tap counter width
  // Comparison width: wide enough that w + strd + flen never truncates.
  localparam int SW = ((IF_ADDR_LEN > FILT_ADDR_LEN) ? IF_ADDR_LEN : FILT_ADDR_LEN) + 3;

  typedef enum logic [1:0] {IDLE, READ, STRIDE, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [IF_ADDR_LEN-1:0]   base_reg, base_next;
  logic [IF_ADDR_LEN:0]     len_reg, len_next;
  logic [KW-1:0]            flen_reg, flen_next;
  logic [IF_ADDR_LEN-1:0]   strd_reg, strd_next;
  logic [WW-1:0]            w_reg, w_next;
  logic [KW-1:0]            k_reg, k_next;
  logic [IF_ADDR_LEN-1:0]   if_addr_reg, if_addr_next;
  logic [FILT_ADDR_LEN-1:0] filt_addr_reg, filt_addr_next;

  logic last_tap;
  logic next_window_fits;
  logic bad_params;

  // Next-state, counter and address computation; psum_done is the only
  // combinational output.
  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    len_next       = len_reg;
    flen_next      = flen_reg;
    strd_next      = strd_reg;
    w_next         = w_reg;
    k_next         = k_reg;
    if_addr_next   = if_addr_reg;
    filt_addr_next = filt_addr_reg;
    psum_done      = 1'b0;

    last_tap         = (k_reg == flen_reg - KW'(1));
    next_window_fits = (SW'(w_reg) + SW'(strd_reg) + SW'(flen_reg)) <= SW'(len_reg);
    bad_params       = (filt_len == '0) || (stride == '0) || (SW'(filt_len) > SW'(if_len));

    case (state_reg)
      READ: begin
        if (rd_ready) begin
          if (last_tap) begin
            psum_done  = 1'b1;
            k_next     = '0;
            state_next = next_window_fits ? STRIDE : DONE;
          end else begin
            k_next = k_reg + KW'(1);
          end
        end
      end
      STRIDE: begin
        w_next     = w_reg + WW'(strd_reg);
        state_next = READ;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
      end
    endcase

    // A start pulse from any state latches a fresh row and aborts the old one.
    if (start_rd_gen) begin
      base_next  = if_base;
      len_next   = if_len;
      flen_next  = filt_len;
      strd_next  = stride;
      w_next     = '0;
      k_next     = '0;
      state_next = bad_params ? DONE : READ;
    end

    if (reset_all) begin
      state_next = IDLE;
      w_next     = '0;
      k_next     = '0;
    end

    // Addresses are registered and only move when a READ cycle follows,
    // so they hold through STRIDE, DONE and IDLE.
    if (state_next == READ) begin
      if_addr_next   = base_next + IF_ADDR_LEN'(w_next) + IF_ADDR_LEN'(k_next);
      filt_addr_next = k_next[FILT_ADDR_LEN-1:0];
    end
  end

  // State, latched row parameters, counters and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      len_reg       <= '0;
      flen_reg      <= '0;
      strd_reg      <= '0;
      w_reg         <= '0;
      k_reg         <= '0;
      if_addr_reg   <= '0;
      filt_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      len_reg       <= len_next;
      flen_reg      <= flen_next;
      strd_reg      <= strd_next;
      w_reg         <= w_next;
      k_reg         <= k_next;
      if_addr_reg   <= if_addr_next;
      filt_addr_reg <= filt_addr_next;
    end
  end

  assign rd_valid          = (state_reg == READ);
  assign stride_count_flag = (state_reg == STRIDE);
  assign full_done         = (state_reg == DONE);
  assign if_addr           = if_addr_reg;
  assign filt_addr         = filt_addr_reg;

endmodule

// File: tb/tb_scratch_read_addr_gen.sv
// Scoreboard bench for scratch_read_addr_gen: the driver pushes the expected
// tap sequence of each row into a queue; a negedge monitor pops and compares.
module tb_scratch_read_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reset_all;
  logic       start_rd_gen;
  logic [3:0] if_base;
  logic [4:0] if_len;
  logic [4:0] filt_len;
  logic [3:0] stride;
  logic       rd_ready;
  logic       rd_valid;
  logic [3:0] if_addr;
  logic [3:0] filt_addr;
  logic       psum_done;
  logic       stride_count_flag;
  logic       full_done;

  scratch_read_addr_gen #(.IF_ADDR_LEN(4), .FILT_ADDR_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .reset_all(reset_all), .start_rd_gen(start_rd_gen),
    .if_base(if_base), .if_len(if_len), .filt_len(filt_len), .stride(stride),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .if_addr(if_addr), .filt_addr(filt_addr),
    .psum_done(psum_done), .stride_count_flag(stride_count_flag), .full_done(full_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ia;
    logic [3:0] fa;
    logic       ps;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_exp = 0;
  int   done_seen = 0;
  int   exp_done_cyc = -1;
  int   ready_mode = 0;
  int   bp_phase = 0;

  logic       prev_psum = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] held_ia = '0;
  logic [3:0] held_fa = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: every window start w = 0, s, 2s, ... whose taps fit in the row.
  task automatic model(input int b, input int l, input int f, input int s, output int nwin);
    txn_t t;
    nwin = 0;
    if (f == 0 || s == 0 || f > l) return;
    for (int w = 0; w + f <= l; w += s) begin
      nwin++;
      for (int k = 0; k < f; k++) begin
        t.ia = 4'((b + w + k) % 16);
        t.fa = 4'(k);
        t.ps = (k == f - 1);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0: rd_ready = 1'b1;
      1: begin
        rd_ready = (bp_phase == 0);
        bp_phase = (bp_phase + 1) % 3;
      end
      default: rd_ready = ($urandom % 4) != 0;
    endcase
  endtask

  // Called just after a rising edge; issues a one-cycle start pulse.
  task automatic start_row(input int b, input int l, input int f, input int s, input int mode);
    int nwin;
    if_base      = 4'(b);
    if_len       = 5'(l);
    filt_len     = 5'(f);
    stride       = 4'(s);
    start_rd_gen = 1'b1;
    ready_mode   = mode;
    bp_phase     = 0;
    exp_q.delete();
    model(b, l, f, s, nwin);
    done_exp     = done_seen + 1;
    if (mode != 0) exp_done_cyc = -1;
    else if (nwin == 0) exp_done_cyc = cyc + 1;
    else exp_done_cyc = cyc + nwin * f + nwin;
    @(posedge clk);
    #1;
    start_rd_gen = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 600;
    while (done_exp > done_seen && budget > 0) begin
      drive_ready();
      @(posedge clk);
      #1;
      budget--;
    end
    chk("row_timeout", (done_exp > done_seen) ? 1 : 0, 0);
    exp_q.delete();
    done_exp = done_seen;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_ready();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_expect();
    exp_q.delete();
    done_exp     = done_seen;
    exp_done_cyc = -1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_rd_valid"}, rd_valid, 0);
    chk({nm, "_if_addr"}, if_addr, 0);
    chk({nm, "_filt_addr"}, filt_addr, 0);
    chk({nm, "_psum_done"}, psum_done, 0);
    chk({nm, "_stride_flag"}, stride_count_flag, 0);
    chk({nm, "_full_done"}, full_done, 0);
  endtask

  // Monitor: compares every transfer and window boundary against the queue.
  always @(negedge clk) begin
    txn_t t;
    logic xfer;
    logic popped_ps;
    if (!rst_n) begin
      prev_psum  <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      xfer      = rd_valid && rd_ready;
      popped_ps = 1'b0;
      if (prev_stall && rd_valid) begin
        chk("hold_if_addr", if_addr, held_ia);
        chk("hold_filt_addr", filt_addr, held_fa);
      end
      if (prev_psum) begin
        chk("stride_after_psum", stride_count_flag, (exp_q.size() > 0) ? 1 : 0);
        chk("done_after_psum", full_done,
            (exp_q.size() == 0 && done_exp > done_seen) ? 1 : 0);
      end else if (stride_count_flag) begin
        chk("stride_spurious", stride_count_flag, 0);
      end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", xfer, 0);
        end else begin
          t = exp_q.pop_front();
          popped_ps = t.ps;
          $display("xfer if_addr=%0d filt_addr=%0d psum_done=%0d (exp %0d/%0d/%0d)",
                   if_addr, filt_addr, psum_done, t.ia, t.fa, t.ps);
          chk("if_addr", if_addr, t.ia);
          chk("filt_addr", filt_addr, t.fa);
          chk("psum_done", psum_done, t.ps);
        end
      end else if (psum_done) begin
        chk("psum_without_transfer", psum_done, 0);
      end
      if (full_done) begin
        $display("full_done at cycle %0d", cyc);
        chk("full_done_expected", full_done,
            (done_exp > done_seen && exp_q.size() == 0) ? 1 : 0);
        if (done_exp > done_seen) begin
          if (exp_done_cyc >= 0) chk("full_done_cycle", cyc, exp_done_cyc);
          done_seen <= done_seen + 1;
        end
      end
      prev_psum  <= xfer && popped_ps;
      prev_stall <= rd_valid && !rd_ready;
      held_ia    <= if_addr;
      held_fa    <= filt_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst_n        = 1'b0;
    reset_all    = 1'b0;
    start_rd_gen = 1'b0;
    if_base      = '0;
    if_len       = '0;
    filt_len     = '0;
    stride       = '0;
    rd_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_cycles(2);

    // Stride 1, stride 2, back-pressure, wrap, degenerate parameters.
    start_row(0, 8, 3, 1, 0);  wait_done();
    start_row(0, 8, 3, 2, 0);  wait_done();
    start_row(0, 8, 3, 1, 1);  wait_done();
    start_row(14, 4, 3, 1, 0); wait_done();
    start_row(3, 4, 5, 1, 0);  wait_done();
    start_row(3, 8, 3, 0, 0);  wait_done();
    start_row(0, 16, 16, 1, 0); wait_done();
    start_row(9, 16, 1, 15, 2); wait_done();

    // Asynchronous reset in the middle of READ.
    start_row(2, 8, 3, 1, 0);
    idle_cycles(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    flush_expect();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // reset_all in the middle of READ: no further transfers, no full_done.
    start_row(4, 10, 4, 1, 0);
    idle_cycles(2);
    reset_all = 1'b1;
    @(posedge clk);
    #1;
    reset_all = 1'b0;
    flush_expect();
    chk("reset_all_idle", rd_valid, 0);
    idle_cycles(6);

    // Restart while in STRIDE: next READ uses the new base from tap 0.
    start_row(0, 8, 3, 1, 0);
    budget = 50;
    while (!stride_count_flag && budget > 0) begin
      drive_ready();
      @(posedge clk);
      #1;
      budget--;
    end
    chk("reached_stride", stride_count_flag, 1);
    start_row(5, 6, 2, 2, 0);
    wait_done();

    // Randomized rows with mixed back-pressure.
    for (int r = 0; r < 30; r++) begin
      int b, l, f, s;
      b = $urandom % 16;
      l = $urandom_range(0, 16);
      f = ($urandom % 8 == 0) ? $urandom_range(0, 16) : $urandom_range(1, 5);
      s = ($urandom % 10 == 0) ? 0 : $urandom_range(1, 4);
      start_row(b, l, f, s, $urandom % 3);
      wait_done();
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
